// File: rtl/sensor_pkg.sv
// Shared definitions for the sensor window buffer slice.
// Contents:
//   - default geometry: 16-bit samples, 8 channels, 5-frame window;
//   - error flag bit positions;
//   - window FSM state type;
//   - flat element index helper.
package sensor_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_N_CH   = 8;
  localparam int unsigned DEF_DEPTH  = 5;

  localparam int unsigned ERR_OVR = 0;  // emission dropped while core busy
  localparam int unsigned ERR_MIS = 1;  // partial frame discarded by sof

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } win_state_e;

  // Flat element index: frame f (0 = oldest), channel c.
  function automatic int unsigned win_idx(input int unsigned f,
                                          input int unsigned c,
                                          input int unsigned n_ch);
    return f * n_ch + c;
  endfunction

endpackage

// File: rtl/sensor_window_buffer_if.sv
// Bus between the sensor front-end / classifier core and the window buffer.
// Signals:
//   - sample side: i_flush, i_valid, i_sof, i_data;
//   - core side:   i_busy, o_next, o_window, o_fill, o_err.
// Modports:
//   - slave:  the window buffer;
//   - master: the environment driving samples and consuming windows.
interface sensor_window_buffer_if
  import sensor_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned N_CH   = DEF_N_CH,
  parameter int unsigned DEPTH  = DEF_DEPTH
) ();

  logic                            i_flush;
  logic                            i_valid;
  logic                            i_sof;
  logic [DATA_W-1:0]               i_data;
  logic                            i_busy;
  logic                            o_next;
  logic [DEPTH*N_CH*DATA_W-1:0]    o_window;
  logic [$clog2(DEPTH+1)-1:0]      o_fill;
  logic [1:0]                      o_err;

  modport slave (
    input  i_flush, i_valid, i_sof, i_data, i_busy,
    output o_next, o_window, o_fill, o_err
  );

  modport master (
    output i_flush, i_valid, i_sof, i_data, i_busy,
    input  o_next, o_window, o_fill, o_err
  );

endinterface

// File: rtl/frame_assembler.sv
// Collects channel-serial samples into one frame.
// Ports:
//   - clk, rst:    clock, asynchronous active-high reset;
//   - flush:       synchronous clear, drops any sample in the same cycle;
//   - valid, sof, data: incoming sample (sof marks channel 0);
//   - frame_valid: this cycle's sample completes a frame;
//   - frame_data:  completed frame, current sample already merged in;
//   - misalign:    sof arrived mid-frame, partial frame discarded.
module frame_assembler
  import sensor_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned N_CH   = DEF_N_CH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     valid,
  input  logic                     sof,
  input  logic [DATA_W-1:0]        data,
  output logic                     frame_valid,
  output logic [N_CH*DATA_W-1:0]   frame_data,
  output logic                     misalign
);

  localparam int unsigned CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);

  logic [CW-1:0]            ch_cnt;
  logic [CW-1:0]            pos;
  logic [N_CH*DATA_W-1:0]   staging;
  logic                     accept;

  always_comb begin
    accept      = valid && !flush;
    pos         = sof ? '0 : ch_cnt;
    misalign    = accept && sof && (ch_cnt != '0);
    frame_valid = accept && (pos == LAST_CH);
    // Current sample bypasses staging so the frame is complete on its edge.
    for (int unsigned c = 0; c < N_CH; c++)
      frame_data[c*DATA_W +: DATA_W] = (pos == CW'(c)) ? data
                                                       : staging[c*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      staging <= '0;
      ch_cnt  <= '0;
    end else if (flush) begin
      staging <= '0;
      ch_cnt  <= '0;
    end else if (accept) begin
      for (int unsigned c = 0; c < N_CH; c++)
        if (pos == CW'(c)) staging[c*DATA_W +: DATA_W] <= data;
      ch_cnt <= frame_valid ? '0 : pos + CW'(1);
    end
  end

endmodule

// File: rtl/sensor_window_buffer.sv
// Sliding window of the last DEPTH sensor frames with snapshot hand-off
// to the classifier core.
// Ports:
//   - i_clk:   clock;
//   - i_rst_n: asynchronous reset, active HIGH despite the name;
//   - bus:     sample input, core handshake, window snapshot, fill and flags.
// Behaviour:
//   - o_window only changes when o_next pulses;
//   - a due emission while the core is busy is dropped and flagged (o_err[0]).
module sensor_window_buffer
  import sensor_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned N_CH   = DEF_N_CH,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned HOP    = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  sensor_window_buffer_if.slave bus
);

  localparam int unsigned FW    = N_CH * DATA_W;
  localparam int unsigned WW    = DEPTH * FW;
  localparam int unsigned FILLW = $clog2(DEPTH + 1);
  localparam int unsigned HW    = (HOP > 1) ? $clog2(HOP) : 1;

  logic             rst;
  logic             frame_valid;
  logic [FW-1:0]    frame_data;
  logic             misalign;

  logic [WW-1:0]    window;
  logic [WW-1:0]    win_shift;
  logic [WW-1:0]    snapshot;
  logic [FILLW-1:0] fill_q;
  logic [HW-1:0]    hop_q;
  logic [1:0]       err_q;
  logic             next_q;

  win_state_e       state_q, state_d;
  logic             due, emit, overrun, last_fill;

  assign rst = i_rst_n;

  frame_assembler #(
    .DATA_W (DATA_W),
    .N_CH   (N_CH)
  ) u_asm (
    .clk         (i_clk),
    .rst         (rst),
    .flush       (bus.i_flush),
    .valid       (bus.i_valid),
    .sof         (bus.i_sof),
    .data        (bus.i_data),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .misalign    (misalign)
  );

  // Window after a commit: everything moves one frame toward f=0.
  always_comb begin
    win_shift = '0;
    for (int unsigned f = 0; f + 1 < DEPTH; f++)
      win_shift[win_idx(f, 0, N_CH)*DATA_W +: FW] =
        window[win_idx(f + 1, 0, N_CH)*DATA_W +: FW];
    win_shift[win_idx(DEPTH - 1, 0, N_CH)*DATA_W +: FW] = frame_data;
  end

  assign last_fill = (fill_q == FILLW'(DEPTH - 1));

  // FSM: state register
  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (bus.i_flush)
      state_d = FILL;
    else if (state_q == FILL && frame_valid && last_fill)
      state_d = RUN;
  end

  // FSM: outputs (the commit that enters RUN is itself due)
  always_comb begin
    due = frame_valid &&
          ((state_q == FILL && last_fill) ||
           (state_q == RUN  && hop_q == HW'(HOP - 1)));
    emit    = due && !bus.i_busy;
    overrun = due &&  bus.i_busy;
  end

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      window   <= '0;
      snapshot <= '0;
      fill_q   <= '0;
      hop_q    <= '0;
      err_q    <= '0;
      next_q   <= 1'b0;
    end else begin
      next_q <= emit;
      if (emit) snapshot <= win_shift;
      if (bus.i_flush) begin
        window <= '0;
        fill_q <= '0;
        hop_q  <= '0;
        err_q  <= '0;
      end else begin
        if (misalign) err_q[ERR_MIS] <= 1'b1;
        if (overrun)  err_q[ERR_OVR] <= 1'b1;
        if (frame_valid) begin
          window <= win_shift;
          if (fill_q != FILLW'(DEPTH)) fill_q <= fill_q + FILLW'(1);
          if (state_q == FILL || due) hop_q <= '0;
          else                        hop_q <= hop_q + HW'(1);
        end
      end
    end
  end

  assign bus.o_next   = next_q;
  assign bus.o_window = snapshot;
  assign bus.o_fill   = fill_q;
  assign bus.o_err    = err_q;

endmodule

// File: tb/tb_sensor_window_buffer.sv
// Testbench for sensor_window_buffer.
// Two instances share one stimulus stream: HOP=1 and HOP=3.
// Both are compared every cycle against a frame-history model.
module tb_sensor_window_buffer;
  import sensor_pkg::*;

  localparam int DW = 16;
  localparam int NC = 8;
  localparam int DP = 5;
  localparam int FW = NC * DW;
  localparam int WW = DP * FW;

  typedef logic [FW-1:0] frame_t;

  logic clk;
  logic rst;

  sensor_window_buffer_if #(.DATA_W(DW), .N_CH(NC), .DEPTH(DP)) bus0 ();
  sensor_window_buffer_if #(.DATA_W(DW), .N_CH(NC), .DEPTH(DP)) bus1 ();

  sensor_window_buffer #(.DATA_W(DW), .N_CH(NC), .DEPTH(DP), .HOP(1)) dut0 (
    .i_clk   (clk),
    .i_rst_n (rst),
    .bus     (bus0)
  );

  sensor_window_buffer #(.DATA_W(DW), .N_CH(NC), .DEPTH(DP), .HOP(3)) dut1 (
    .i_clk   (clk),
    .i_rst_n (rst),
    .bus     (bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_pass = 0;
  int nx0    = 0;

  // Reference model: history of committed frames, newest at the back.
  frame_t         m_hist [2][$];
  logic [DW-1:0]  m_stage[2][NC];
  int             m_ch   [2];
  int             m_fill [2];
  int             m_run  [2];   // commits since window became full, -1 before
  logic [1:0]     m_err  [2];
  logic [WW-1:0]  m_snap [2];
  bit             m_next [2];
  int             hop_of [2] = '{1, 3};

  task automatic check_val(input string tag, input logic [WW-1:0] got,
                           input logic [WW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] elem(input logic [WW-1:0] w, input int k);
    return w[k*DW +: DW];
  endfunction

  function automatic logic [WW-1:0] pack_hist(input int d);
    logic [WW-1:0] w = '0;
    for (int f = 0; f < m_hist[d].size(); f++) w[f*FW +: FW] = m_hist[d][f];
    return w;
  endfunction

  task automatic model_reset(input bit keep_snap);
    for (int d = 0; d < 2; d++) begin
      m_hist[d].delete();
      m_ch[d]   = 0;
      m_fill[d] = 0;
      m_run[d]  = -1;
      m_err[d]  = 2'b00;
      m_next[d] = 1'b0;
      if (!keep_snap) m_snap[d] = '0;
    end
  endtask

  task automatic model_edge(input bit v, input bit s, input logic [DW-1:0] dat,
                            input bit b, input bit f);
    for (int d = 0; d < 2; d++) begin
      m_next[d] = 1'b0;
      if (f) begin
        m_hist[d].delete();
        m_ch[d] = 0; m_fill[d] = 0; m_run[d] = -1; m_err[d] = 2'b00;
      end else if (v) begin
        int pos;
        pos = s ? 0 : m_ch[d];
        if (s && m_ch[d] != 0) m_err[d][1] = 1'b1;
        m_stage[d][pos] = dat;
        m_ch[d] = pos + 1;
        if (pos == NC - 1) begin
          frame_t fr;
          for (int c = 0; c < NC; c++) fr[c*DW +: DW] = m_stage[d][c];
          m_ch[d] = 0;
          m_hist[d].push_back(fr);
          if (m_hist[d].size() > DP) void'(m_hist[d].pop_front());
          if (m_fill[d] < DP) m_fill[d]++;
          if (m_fill[d] == DP) begin
            m_run[d]++;
            if (m_run[d] % hop_of[d] == 0) begin
              if (b) m_err[d][0] = 1'b1;
              else begin
                m_snap[d] = pack_hist(d);
                m_next[d] = 1'b1;
              end
            end
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    if (bus0.o_next === 1'b1) nx0++;
    check_val("d0_next", WW'(bus0.o_next), WW'(m_next[0]));
    check_val("d0_fill", WW'(bus0.o_fill), WW'(m_fill[0]));
    check_val("d0_err",  WW'(bus0.o_err),  WW'(m_err[0]));
    check_val("d0_win",  bus0.o_window,    m_snap[0]);
    check_val("d1_next", WW'(bus1.o_next), WW'(m_next[1]));
    check_val("d1_fill", WW'(bus1.o_fill), WW'(m_fill[1]));
    check_val("d1_err",  WW'(bus1.o_err),  WW'(m_err[1]));
    check_val("d1_win",  bus1.o_window,    m_snap[1]);
  endtask

  task automatic drive(input bit v, input bit s, input logic [DW-1:0] dat,
                       input bit b, input bit f);
    bus0.i_valid = v; bus0.i_sof = s; bus0.i_data = dat; bus0.i_busy = b; bus0.i_flush = f;
    bus1.i_valid = v; bus1.i_sof = s; bus1.i_data = dat; bus1.i_busy = b; bus1.i_flush = f;
  endtask

  // One clock edge: inputs set between edges, outputs checked 1 time unit after.
  task automatic step(input bit v, input bit s, input logic [DW-1:0] dat,
                      input bit b, input bit f);
    drive(v, s, dat, b, f);
    @(posedge clk);
    model_edge(v, s, dat, b, f);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    model_reset(1'b0);
    compare_all();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send_sample(input int fr, input int c, input bit b, input int max_gap);
    int gap;
    gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
    for (int i = 0; i < gap; i++) step(1'b0, 1'b0, DW'($urandom), b, 1'b0);
    step(1'b1, (c == 0), DW'(fr * 16 + c), b, 1'b0);
  endtask

  task automatic send_frame(input int fr, input bit b, input int max_gap);
    for (int c = 0; c < NC; c++) send_sample(fr, c, b, max_gap);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    do_reset();

    // Five aligned frames: one emission right after the 40th sample.
    nx0 = 0;
    for (int fr = 0; fr < 5; fr++) send_frame(fr, 1'b0, 0);
    check_val("t1_pulses", WW'(nx0), WW'(1));
    check_val("t1_e0",  WW'(elem(bus0.o_window, 0)),  WW'(16'h0000));
    check_val("t1_e39", WW'(elem(bus0.o_window, 39)), WW'(16'h0047));
    check_val("t1_fill", WW'(bus0.o_fill), WW'(5));
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);

    // Sixth frame slides the window by one.
    send_frame(5, 1'b0, 2);
    check_val("t2_e0",  WW'(elem(bus0.o_window, 0)),  WW'(16'h0010));
    check_val("t2_e39", WW'(elem(bus0.o_window, 39)), WW'(16'h0057));

    // Frames 6..11: HOP=3 instance emits after frames 7 and 10 only.
    for (int fr = 6; fr < 12; fr++) begin
      send_frame(fr, 1'b0, 2);
      if (fr == 10) check_val("t3_h3_e39", WW'(elem(bus1.o_window, 39)), WW'(16'h00a7));
    end
    check_val("t3_h3_hold", WW'(elem(bus1.o_window, 39)), WW'(16'h00a7));
    check_val("t3_h1_e39",  WW'(elem(bus0.o_window, 39)), WW'(16'h00b7));

    // Busy across the sixth commit: overrun, snapshot held, next commit emits.
    do_reset();
    for (int fr = 0; fr < 5; fr++) send_frame(fr, 1'b0, 1);
    send_frame(5, 1'b1, 1);
    check_val("t4_err",  WW'(bus0.o_err), WW'(2'b01));
    check_val("t4_e39h", WW'(elem(bus0.o_window, 39)), WW'(16'h0047));
    send_frame(6, 1'b0, 1);
    check_val("t4_e0",  WW'(elem(bus0.o_window, 0)),  WW'(16'h0020));
    check_val("t4_e39", WW'(elem(bus0.o_window, 39)), WW'(16'h0067));

    // sof after three samples: misalign flag, frame restarts.
    do_reset();
    for (int c = 0; c < 3; c++) send_sample(0, c, 1'b0, 0);
    send_frame(1, 1'b0, 0);
    check_val("t5_mis",  WW'(bus0.o_err[1]), WW'(1));
    check_val("t5_fill", WW'(bus0.o_fill), WW'(1));

    // Flush together with a sample at fill=3.
    do_reset();
    for (int fr = 0; fr < 3; fr++) send_frame(fr, 1'b0, 0);
    send_sample(3, 0, 1'b0, 0);
    step(1'b1, 1'b0, 16'h1234, 1'b0, 1'b1);
    check_val("t6_fill", WW'(bus0.o_fill), WW'(0));
    check_val("t6_err",  WW'(bus0.o_err),  WW'(0));
    nx0 = 0;
    for (int fr = 10; fr < 14; fr++) send_frame(fr, 1'b0, 1);
    check_val("t6_nonext", WW'(nx0), WW'(0));
    send_frame(14, 1'b0, 1);
    check_val("t6_next", WW'(nx0), WW'(1));

    // Reset asserted mid-frame, then refill from empty.
    for (int fr = 0; fr < 2; fr++) send_frame(fr, 1'b0, 0);
    for (int c = 0; c < 4; c++) send_sample(2, c, 1'b0, 0);
    #2;
    do_reset();
    nx0 = 0;
    for (int fr = 0; fr < 5; fr++) send_frame(fr + 20, 1'b0, 1);
    check_val("t7_next", WW'(nx0), WW'(1));

    // Randomised traffic: gaps, busy, sporadic misalign and flush.
    for (int i = 0; i < 3000; i++) begin
      bit v, s, b, f;
      v = ($urandom_range(0, 99) < 70);
      s = v && ($urandom_range(0, 99) < ((m_ch[0] == 0) ? 50 : 3));
      b = ($urandom_range(0, 99) < 30);
      f = ($urandom_range(0, 999) < 8);
      step(v, s, DW'($urandom), b, f);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
